wb_sdram_arbiter: RTL and testbench
===================================

Name: wb_sdram_arbiter

Overview:
- Two-master, one-slave Wishbone classic arbiter that shares the single SDRAM controller port in the nanorv32 SoC.
- Master 0 is the instruction bus; master 1 is the data bus.
- Arbitration is round-robin, and the grant is held for the whole cycle (cyc) of the winning master.
- A bus watchdog terminates hung slave accesses with err so the CPU never stalls forever.

Parameters:
- AW, 32, address width of all ports.
- DW, 32, data width of all ports; SEL width is DW/8.
- TIMEOUT_CYCLES, 255, number of stb-without-ack/err cycles before a forced err; 0 disables the watchdog.

Ports:
- clock  in  1  Wishbone clock; all logic is single-clock.
- reset  in  1  synchronous, active-high reset.
- m0_adr_i / m1_adr_i  in  AW  master address.
- m0_dat_i / m1_dat_i  in  DW  master write data.
- m0_sel_i / m1_sel_i  in  DW/8  byte selects.
- m0_we_i / m1_we_i  in  1  write enable.
- m0_cyc_i / m1_cyc_i  in  1  bus cycle request.
- m0_stb_i / m1_stb_i  in  1  strobe.
- m0_dat_o / m1_dat_o  out  DW  read data; both are driven from s_dat_i.
- m0_ack_o / m1_ack_o  out  1  acknowledge; asserted only to the granted master.
- m0_err_o / m1_err_o  out  1  error; comes from the slave err or the watchdog.
- s_adr_o  out  AW  slave address.
- s_dat_o  out  DW  slave write data.
- s_sel_o  out  DW/8  slave byte selects.
- s_we_o  out  1  slave write enable.
- s_cyc_o  out  1  slave cycle.
- s_stb_o  out  1  slave strobe.
- s_dat_i  in  DW  slave read data.
- s_ack_i  in  1  slave acknowledge.
- s_err_i  in  1  slave error.

Behaviour:
- State register with three states: IDLE, GNT0, GNT1. A last_grant bit records which master was granted most recently. Watchdog counter width is clog2(TIMEOUT_CYCLES+1).
- On reset:
  - State goes to IDLE; last_grant=1, so m0 wins the first tie.
  - Watchdog counter is 0.
  - All s_* outputs and all ack/err outputs are 0.
  - Reset asserted mid-transfer drops s_cyc_o/s_stb_o on the next edge and discards any pending ack.
- IDLE:
  - Only m0_cyc_i -> GNT0. Only m1_cyc_i -> GNT1.
  - Both requesting -> the master != last_grant is granted.
  - The grant takes effect the cycle after the request, giving 1 cycle of arbitration latency.
  - All s_* outputs are 0 while in IDLE.
- GNTx:
  - s_adr/dat/sel/we/cyc/stb are combinationally mux'd from master x.
  - mx_ack_o = s_ack_i; mx_err_o = s_err_i or watchdog fire.
  - The non-granted master's ack/err are 0 at all times.
- Release:
  - In GNTx with mx_cyc_i=0 at the edge: if the other master has cyc=1 -> GNT(other) directly, with no IDLE bubble; otherwise -> IDLE.
  - last_grant is updated to x on entry to GNTx.
  - Back-to-back stb within one cyc stays on the same grant, so the other master never preempts a locked cycle.
- Watchdog:
  - Counts clock edges while s_cyc_o&s_stb_o&!s_ack_i&!s_err_i.
  - Clears on ack, on err, or when stb drops.
  - When count==TIMEOUT_CYCLES-1 and still no ack, in that cycle: mx_err_o=1, s_stb_o forced to 0, counter clears.
  - A slave ack arriving in the same cycle as the fire takes priority: ack=1, err=0.
- Simultaneous events: release by master x plus a new request from x in the same cycle where the other master is also waiting -> the other master wins, which is the fairness rule.
- No registered datapath: ack/data latency through the arbiter is 0 cycles once granted.

Test Plan:
- Reset, then m0 single read to 0x0000_0100 with slave ack 2 cycles after stb -> s_cyc_o rises 1 cycle after m0_cyc_i; m0_ack_o pulses once; m0_dat_o=s_dat_i=0xDEADBEEF; m1_ack_o stays 0.
- m0 and m1 assert cyc in the same cycle -> m0 is granted first. After m0 drops cyc, m1 is granted on the next edge with no IDLE cycle. In a repeat of the tie, m1 wins.
- m1 holds cyc across 4 back-to-back stb writes (sel=0xF, data 0x1..0x4) while m0 requests -> m0 is not granted until m1 drops cyc; the slave sees writes 0x1..0x4 in order.
- TIMEOUT_CYCLES=8, slave never acks a m0 read -> m0_err_o=1 on the 8th stb cycle; s_stb_o=0 in that cycle; the counter returns to 0.
- Slave ack arrives exactly on the watchdog-fire cycle -> m0_ack_o=1, m0_err_o=0.
- Reset asserted during GNT1 with stb pending -> the next cycle has s_cyc_o=0, state IDLE, m1_ack_o=0; a subsequent tie grants m0.

Source files
------------

// File: rtl/wb_sdram_arbiter.sv
// wb_sdram_arbiter: two-master, one-slave Wishbone classic arbiter that shares
// the single SDRAM controller port. Master 0 is the instruction bus and
// master 1 is the data bus.
// Arbitration is round-robin. A grant is held for the whole cyc of the winning
// master. A bus watchdog ends a hung slave access with err.
//
// Ports
//   clock, reset         single clock, synchronous active-high reset
//   m0_* / m1_*          master ports (adr, dat, sel, we, cyc, stb in;
//                        dat, ack, err out)
//   s_*_o                slave request, muxed combinationally from the granted master
//   s_dat_i/ack_i/err_i  slave response, routed back to the granted master
module wb_sdram_arbiter #(
    parameter int unsigned AW             = 32,
    parameter int unsigned DW             = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic            clock,
    input  logic            reset,

    input  logic [AW-1:0]   m0_adr_i,
    input  logic [DW-1:0]   m0_dat_i,
    input  logic [DW/8-1:0] m0_sel_i,
    input  logic            m0_we_i,
    input  logic            m0_cyc_i,
    input  logic            m0_stb_i,
    output logic [DW-1:0]   m0_dat_o,
    output logic            m0_ack_o,
    output logic            m0_err_o,

    input  logic [AW-1:0]   m1_adr_i,
    input  logic [DW-1:0]   m1_dat_i,
    input  logic [DW/8-1:0] m1_sel_i,
    input  logic            m1_we_i,
    input  logic            m1_cyc_i,
    input  logic            m1_stb_i,
    output logic [DW-1:0]   m1_dat_o,
    output logic            m1_ack_o,
    output logic            m1_err_o,

    output logic [AW-1:0]   s_adr_o,
    output logic [DW-1:0]   s_dat_o,
    output logic [DW/8-1:0] s_sel_o,
    output logic            s_we_o,
    output logic            s_cyc_o,
    output logic            s_stb_o,
    input  logic [DW-1:0]   s_dat_i,
    input  logic            s_ack_i,
    input  logic            s_err_i
);

    localparam int unsigned SW      = DW / 8;
    localparam bit          WD_ON   = (TIMEOUT_CYCLES != 0);
    // A width of at least 1 keeps the counter declarable when the watchdog is disabled.
    localparam int unsigned CW      = WD_ON ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int unsigned FIRE_AT = WD_ON ? TIMEOUT_CYCLES - 1 : 0;
    localparam logic [CW-1:0] FIRE_CNT = CW'(FIRE_AT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          last_grant_q, last_grant_d;
    logic [CW-1:0] wd_cnt_q, wd_cnt_d;

    logic          gnt0, gnt1;
    logic          raw_stb;
    logic          wd_wait;
    logic          wd_fire;

    // State, fairness bit and watchdog counter.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            wd_cnt_q     <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            wd_cnt_q     <= wd_cnt_d;
        end
    end

    // Bus mux, response routing and watchdog. Reset gates everything so that
    // an ack pending at reset is never delivered.
    always_comb begin
        gnt0     = 1'b0;
        gnt1     = 1'b0;
        raw_stb  = 1'b0;
        wd_wait  = 1'b0;
        wd_fire  = 1'b0;
        wd_cnt_d = '0;
        s_adr_o  = '0;
        s_dat_o  = '0;
        s_sel_o  = '0;
        s_we_o   = 1'b0;
        s_cyc_o  = 1'b0;
        s_stb_o  = 1'b0;
        m0_ack_o = 1'b0;
        m0_err_o = 1'b0;
        m1_ack_o = 1'b0;
        m1_err_o = 1'b0;
        m0_dat_o = s_dat_i;
        m1_dat_o = s_dat_i;

        gnt0 = (state_q == GNT0) && !reset;
        gnt1 = (state_q == GNT1) && !reset;

        if (gnt0) begin
            s_adr_o = m0_adr_i;
            s_dat_o = m0_dat_i;
            s_sel_o = SW'(m0_sel_i);
            s_we_o  = m0_we_i;
            s_cyc_o = m0_cyc_i;
            raw_stb = m0_stb_i;
        end else if (gnt1) begin
            s_adr_o = m1_adr_i;
            s_dat_o = m1_dat_i;
            s_sel_o = SW'(m1_sel_i);
            s_we_o  = m1_we_i;
            s_cyc_o = m1_cyc_i;
            raw_stb = m1_stb_i;
        end

        // Fire requires no ack in this cycle, so a late ack still wins.
        wd_wait = s_cyc_o && raw_stb && !s_ack_i && !s_err_i;
        wd_fire = WD_ON && wd_wait && (wd_cnt_q == FIRE_CNT);
        s_stb_o = raw_stb && !wd_fire;

        if (WD_ON && wd_wait && !wd_fire) begin
            wd_cnt_d = wd_cnt_q + CW'(1);
        end

        m0_ack_o = gnt0 && s_ack_i;
        m0_err_o = gnt0 && (s_err_i || wd_fire);
        m1_ack_o = gnt1 && s_ack_i;
        m1_err_o = gnt1 && (s_err_i || wd_fire);
    end

    // Round-robin grant FSM. A release hands over directly to a waiting master.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;

        case (state_q)
            IDLE: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    state_d = last_grant_q ? GNT0 : GNT1;
                end else if (m0_cyc_i) begin
                    state_d = GNT0;
                end else if (m1_cyc_i) begin
                    state_d = GNT1;
                end
            end
            GNT0: begin
                if (!m0_cyc_i) begin
                    state_d = m1_cyc_i ? GNT1 : IDLE;
                end
            end
            GNT1: begin
                if (!m1_cyc_i) begin
                    state_d = m0_cyc_i ? GNT0 : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (state_d == GNT0 && state_q != GNT0) begin
            last_grant_d = 1'b0;
        end else if (state_d == GNT1 && state_q != GNT1) begin
            last_grant_d = 1'b1;
        end
    end

endmodule

// File: tb/tb_wb_sdram_arbiter.sv
// Directed bench for wb_sdram_arbiter. The watchdog is set to 8 cycles.
// Inputs change 2 ns after a rising edge. Outputs are checked 1 ns later.
module tb_wb_sdram_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam logic [31:0] ADR_A = 32'h0000_0100;
    localparam logic [31:0] ADR_B = 32'h0000_0200;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [AW-1:0] m0_adr_i = '0, m1_adr_i = '0;
    logic [DW-1:0] m0_dat_i = '0, m1_dat_i = '0;
    logic [3:0]    m0_sel_i = '0, m1_sel_i = '0;
    logic          m0_we_i = 1'b0, m1_we_i = 1'b0;
    logic          m0_cyc_i = 1'b0, m1_cyc_i = 1'b0;
    logic          m0_stb_i = 1'b0, m1_stb_i = 1'b0;
    logic [DW-1:0] m0_dat_o, m1_dat_o;
    logic          m0_ack_o, m1_ack_o, m0_err_o, m1_err_o;
    logic [AW-1:0] s_adr_o;
    logic [DW-1:0] s_dat_o;
    logic [3:0]    s_sel_o;
    logic          s_we_o, s_cyc_o, s_stb_o;
    logic [DW-1:0] s_dat_i = '0;
    logic          s_ack_i = 1'b0;
    logic          s_err_i = 1'b0;

    int n_checks = 0;
    int n_bad    = 0;

    wb_sdram_arbiter #(.AW(AW), .DW(DW), .TIMEOUT_CYCLES(8)) dut (
        .clock(clock), .reset(reset),
        .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_sel_i(m0_sel_i),
        .m0_we_i(m0_we_i), .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i),
        .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
        .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_sel_i(m1_sel_i),
        .m1_we_i(m1_we_i), .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i),
        .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
        .s_we_o(s_we_o), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o),
        .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        // Reset state.
        tick();
        settle();
        check("rst_s_cyc", 64'(s_cyc_o), 64'd0);
        check("rst_s_stb", 64'(s_stb_o), 64'd0);
        check("rst_m0_ack", 64'(m0_ack_o), 64'd0);
        check("rst_m1_err", 64'(m1_err_o), 64'd0);
        reset = 1'b0;

        // m0 single read; the slave acks on the third stb cycle.
        m0_adr_i = ADR_A; m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_we_i = 1'b0;
        settle();
        check("rd_arb_latency", 64'(s_cyc_o), 64'd0);
        tick(); settle();
        check("rd_s_cyc", 64'(s_cyc_o), 64'd1);
        check("rd_s_adr", 64'(s_adr_o), 64'(ADR_A));
        check("rd_ack_early", 64'(m0_ack_o), 64'd0);
        tick(); settle();
        check("rd_ack_wait", 64'(m0_ack_o), 64'd0);
        tick();
        s_ack_i = 1'b1; s_dat_i = 32'hDEAD_BEEF;
        settle();
        check("rd_m0_ack", 64'(m0_ack_o), 64'd1);
        check("rd_m0_dat", 64'(m0_dat_o), 64'hDEAD_BEEF);
        check("rd_m1_ack", 64'(m1_ack_o), 64'd0);
        tick();
        s_ack_i = 1'b0; m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
        settle();
        check("rd_ack_once", 64'(m0_ack_o), 64'd0);
        tick(); settle();
        check("rd_idle", 64'(s_cyc_o), 64'd0);

        // A tie after reset goes to m0, then hands over to m1 without an idle cycle.
        do_reset();
        m0_adr_i = ADR_A; m1_adr_i = ADR_B;
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
        tick(); settle();
        check("tie1_adr", 64'(s_adr_o), 64'(ADR_A));
        check("tie1_cyc", 64'(s_cyc_o), 64'd1);
        m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
        tick(); settle();
        check("handover_cyc", 64'(s_cyc_o), 64'd1);
        check("handover_adr", 64'(s_adr_o), 64'(ADR_B));
        m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
        tick(); settle();
        check("tie_idle", 64'(s_cyc_o), 64'd0);
        // m0 alone makes m0 the most recent winner.
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
        tick(); settle();
        check("m0_solo_adr", 64'(s_adr_o), 64'(ADR_A));
        m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
        tick();
        // A repeat of the tie now goes to m1.
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
        tick(); settle();
        check("tie2_adr", 64'(s_adr_o), 64'(ADR_B));

        // m1 locked burst of four writes while m0 keeps requesting.
        m1_we_i = 1'b1; m1_sel_i = 4'hF; s_ack_i = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            m1_dat_i = 32'(i);
            settle();
            check("burst_dat", 64'(s_dat_o), 64'(i));
            check("burst_adr", 64'(s_adr_o), 64'(ADR_B));
            check("burst_m1_ack", 64'(m1_ack_o), 64'd1);
            check("burst_m0_ack", 64'(m0_ack_o), 64'd0);
            tick();
        end
        s_ack_i = 1'b0; m1_cyc_i = 1'b0; m1_stb_i = 1'b0; m1_we_i = 1'b0;
        settle();
        check("burst_sel", 64'(s_sel_o), 64'hF);
        tick(); settle();
        check("burst_m0_after", 64'(s_adr_o), 64'(ADR_A));
        check("burst_m0_cyc", 64'(s_cyc_o), 64'd1);
        // Slave err is passed through to the granted master.
        s_err_i = 1'b1;
        settle();
        check("slave_err", 64'(m0_err_o), 64'd1);
        s_err_i = 1'b0;
        m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
        tick(); tick();

        // Watchdog fires on the 8th unanswered stb cycle.
        m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
        tick();
        for (int c = 1; c <= 7; c++) begin
            settle();
            check("wd_no_err", 64'(m0_err_o), 64'd0);
            tick();
        end
        settle();
        check("wd_fire_err", 64'(m0_err_o), 64'd1);
        check("wd_fire_stb", 64'(s_stb_o), 64'd0);
        check("wd_m1_err", 64'(m1_err_o), 64'd0);
        tick(); settle();
        check("wd_clear_err", 64'(m0_err_o), 64'd0);
        check("wd_clear_stb", 64'(s_stb_o), 64'd1);
        m0_stb_i = 1'b0;
        tick();

        // An ack in the fire cycle wins over the watchdog.
        m0_stb_i = 1'b1;
        for (int c = 1; c <= 7; c++) tick();
        s_ack_i = 1'b1;
        settle();
        check("wd_ack_ack", 64'(m0_ack_o), 64'd1);
        check("wd_ack_err", 64'(m0_err_o), 64'd0);
        check("wd_ack_stb", 64'(s_stb_o), 64'd1);
        tick();
        s_ack_i = 1'b0; m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
        tick();

        // Reset during a pending m1 access.
        m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
        tick(); settle();
        check("rst_mid_gnt1", 64'(s_cyc_o), 64'd1);
        reset = 1'b1; m0_cyc_i = 1'b1; m0_stb_i = 1'b1; s_ack_i = 1'b1;
        settle();
        check("rst_mid_drop_ack", 64'(m1_ack_o), 64'd0);
        tick();
        reset = 1'b0; s_ack_i = 1'b0;
        settle();
        check("rst_mid_cyc", 64'(s_cyc_o), 64'd0);
        check("rst_mid_m1_ack", 64'(m1_ack_o), 64'd0);
        tick(); settle();
        check("rst_mid_tie_m0", 64'(s_adr_o), 64'(ADR_A));

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
